// File: rtl/branch_resolver_pkg.sv
// Shared encodings for the ID-stage branch resolver: branch types, comparer
// select values and FSM states.
package branch_resolver_pkg;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLEZ = 3'd2;
    localparam logic [2:0] BR_BGTZ = 3'd3;
    localparam logic [2:0] BR_BLTZ = 3'd4;
    localparam logic [2:0] BR_BGEZ = 3'd5;

    // Comparer select: subtract D2 from D1, or compare D1 against zero.
    localparam logic CMP_SUB  = 1'b1;
    localparam logic CMP_ZERO = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_OPND = 2'd1,
        ST_REDIRECT  = 2'd2
    } br_state_e;

endpackage

// File: rtl/branch_resolver_cond.sv
// Branch condition evaluation: turns br_type plus the comparer flags into a
// taken decision. Reserved encodings are never taken and flagged illegal.
module br_cond_eval
    import branch_resolver_pkg::*;
(
    input  logic [2:0] br_type,
    input  logic       cmp_zero,
    input  logic       cmp_lzero,
    output logic       taken,
    output logic       illegal
);

    // Decode the taken condition for each branch type.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (br_type)
            BR_BEQ:  taken = cmp_zero;
            BR_BNE:  taken = !cmp_zero;
            BR_BLEZ: taken = cmp_zero | cmp_lzero;
            BR_BGTZ: taken = !cmp_zero & !cmp_lzero;
            BR_BLTZ: taken = cmp_lzero;
            BR_BGEZ: taken = !cmp_lzero;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// ID-stage branch resolver. Waits for forwarded operands, resolves the branch
// with a one-cycle registered result, holds a taken redirect until fetch
// acknowledges it and keeps saturating taken/total statistics.
//
// Handshakes: a branch is consumed in the cycle br_valid & opnd_ready is seen
// while the FSM is IDLE or WAIT_OPND and no flush is asserted; decode must hold
// the branch while stall_d is high. The redirect is offered on redirect_valid
// and retired in the cycle fetch_ack is high; redirect_pc does not change
// while redirect_valid is high.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid,
    input  logic [2:0]        br_type,
    input  logic [ADDR_W-1:0] pc_d,
    input  logic [15:0]       imm16,
    input  logic              opnd_ready,
    input  logic              cmp_zero,
    input  logic              cmp_lzero,
    input  logic              fetch_ack,
    input  logic              flush,
    output logic              cmp_op,
    output logic              stall_d,
    output logic              br_done,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              illegal_br,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  total_cnt,
    output logic [1:0]        state_dbg
);

    br_state_e         state_q;
    br_state_e         state_d;
    logic              taken;
    logic              illegal;
    logic              resolve;
    logic signed [31:0] offset;
    logic [ADDR_W-1:0] target;

    br_cond_eval u_cond (
        .br_type   (br_type),
        .cmp_zero  (cmp_zero),
        .cmp_lzero (cmp_lzero),
        .taken     (taken),
        .illegal   (illegal)
    );

    assign cmp_op = ((br_type == BR_BEQ) || (br_type == BR_BNE)) ? CMP_SUB : CMP_ZERO;

    // Word offset scaled to bytes; the add wraps at ADDR_W bits.
    assign offset = {{14{imm16[15]}}, imm16, 2'b00};
    assign target = pc_d + ADDR_W'(4) + ADDR_W'(offset);

    assign redirect_valid = (state_q == ST_REDIRECT);
    assign state_dbg      = state_q;

    // Next-state, stall and resolve decision; flush overrides everything.
    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        resolve = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
                    if (opnd_ready) begin
                        resolve = 1'b1;
                    end else begin
                        stall_d = 1'b1;
                        state_d = ST_WAIT_OPND;
                    end
                end
            end
            ST_WAIT_OPND: begin
                stall_d = br_valid & !opnd_ready;
                if (!br_valid) begin
                    state_d = ST_IDLE;
                end else if (opnd_ready) begin
                    resolve = 1'b1;
                end
            end
            ST_REDIRECT: begin
                // A new branch waits here; it is evaluated only once back in IDLE.
                stall_d = br_valid;
                if (fetch_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (resolve) begin
            state_d = taken ? ST_REDIRECT : ST_IDLE;
        end
        if (flush) begin
            state_d = ST_IDLE;
            resolve = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered resolution pulses and the latched redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_done     <= 1'b0;
            illegal_br  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            br_done    <= resolve;
            illegal_br <= resolve & illegal;
            if (resolve && taken) begin
                redirect_pc <= target;
            end
        end
    end

    // Saturating branch statistics, advanced with each resolution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= '0;
            total_cnt <= '0;
        end else if (resolve) begin
            if (total_cnt != {CNT_W{1'b1}}) begin
                total_cnt <= total_cnt + CNT_W'(1);
            end
            if (taken && (taken_cnt != {CNT_W{1'b1}})) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: reset, a flag table, directed multi-cycle
// sequences, randomized branches against an operand-level model, counter
// saturation and asynchronous reset.
module tb_branch_resolver;

  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              br_valid;
  logic [2:0]        br_type;
  logic [ADDR_W-1:0] pc_d;
  logic [15:0]       imm16;
  logic              opnd_ready;
  logic              cmp_zero;
  logic              cmp_lzero;
  logic              fetch_ack;
  logic              flush;
  logic              cmp_op;
  logic              stall_d;
  logic              br_done;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              illegal_br;
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  total_cnt;
  logic [1:0]        state_dbg;

  int checks;
  int errors;
  int exp_taken_cnt;
  int exp_total_cnt;

  typedef struct {
    logic [2:0] t;
    logic       z;
    logic       lz;
    logic       exp_tk;
    logic       exp_il;
  } vec_t;

  vec_t vecs[16];

  branch_resolver #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_valid       (br_valid),
    .br_type        (br_type),
    .pc_d           (pc_d),
    .imm16          (imm16),
    .opnd_ready     (opnd_ready),
    .cmp_zero       (cmp_zero),
    .cmp_lzero      (cmp_lzero),
    .fetch_ack      (fetch_ack),
    .flush          (flush),
    .cmp_op         (cmp_op),
    .stall_d        (stall_d),
    .br_done        (br_done),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .illegal_br     (illegal_br),
    .taken_cnt      (taken_cnt),
    .total_cnt      (total_cnt),
    .state_dbg      (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [15:0] imm);
    int off;
    off = int'(signed'(imm)) * 4;
    return pc + 32'd4 + $unsigned(off);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Present a branch, hold opnd_ready low for rdy_dly cycles, then check the
  // resolution cycle. Returns just after the resolving edge with br_valid low.
  task automatic do_branch(input logic [2:0] t, input logic [31:0] pc, input logic [15:0] imm,
                           input logic z, input logic lz, input int rdy_dly,
                           input logic exp_tk, input logic exp_il);
    br_valid   = 1'b1;
    br_type    = t;
    pc_d       = pc;
    imm16      = imm;
    cmp_zero   = z;
    cmp_lzero  = lz;
    opnd_ready = (rdy_dly == 0);
    for (int i = 0; i < rdy_dly; i++) begin
      #1;
      chk("stall_wait", stall_d, 1'b1);
      chk("done_wait", br_done, 1'b0);
      @(posedge clk); #1;
      if (i == rdy_dly - 1) opnd_ready = 1'b1;
    end
    #1;
    chk("cmp_op", cmp_op, (t == 3'd0 || t == 3'd1));
    chk("stall_ready", stall_d, 1'b0);
    chk("done_pre", br_done, 1'b0);
    @(posedge clk); #1;
    br_valid   = 1'b0;
    opnd_ready = 1'b0;
    exp_total_cnt = sat_inc(exp_total_cnt);
    if (exp_tk) exp_taken_cnt = sat_inc(exp_taken_cnt);
    chk("br_done", br_done, 1'b1);
    chk("illegal_br", illegal_br, exp_il);
    chk("redirect_valid", redirect_valid, exp_tk);
    if (exp_tk) chk("redirect_pc", redirect_pc, model_target(pc, imm));
    chk("taken_cnt", taken_cnt, exp_taken_cnt);
    chk("total_cnt", total_cnt, exp_total_cnt);
  endtask

  // Withhold fetch_ack for dly cycles, then acknowledge the redirect.
  task automatic do_ack(input int dly, input logic [31:0] exp_pc);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("rv_hold", redirect_valid, 1'b1);
      chk("rpc_hold", redirect_pc, exp_pc);
      chk("done_once", br_done, 1'b0);
    end
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    chk("rv_drop", redirect_valid, 1'b0);
    chk("done_after_ack", br_done, 1'b0);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("done_idle", br_done, 1'b0);
    chk("rv_idle", redirect_valid, 1'b0);
    chk("illegal_idle", illegal_br, 1'b0);
  endtask

  initial begin
    int d1, d2, diff, rdy;
    logic [2:0] t;
    logic tk;
    logic [31:0] pc;
    logic [15:0] imm;

    checks = 0; errors = 0;
    exp_taken_cnt = 0; exp_total_cnt = 0;
    rst_n = 1'b0;
    br_valid = 1'b0; br_type = 3'd0; pc_d = '0; imm16 = '0;
    opnd_ready = 1'b0; cmp_zero = 1'b0; cmp_lzero = 1'b0;
    fetch_ack = 1'b0; flush = 1'b0;

    // flag table: type, zero, lzero, taken, illegal
    vecs[0]  = '{3'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{3'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'd4, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'd5, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{3'd5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{3'd6, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{3'd7, 1'b1, 1'b0, 1'b0, 1'b1};

    // reset state
    #1;
    chk("rst_done", br_done, 1'b0);
    chk("rst_rv", redirect_valid, 1'b0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_illegal", illegal_br, 1'b0);
    chk("rst_taken", taken_cnt, 0);
    chk("rst_total", total_cnt, 0);
    chk("rst_stall", stall_d, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // BEQ taken, target 0x00400014
    do_branch(3'd0, 32'h0040_0000, 16'h0004, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    chk("beq_target", redirect_pc, 32'h0040_0014);
    do_ack(0, 32'h0040_0014);

    // BNE with zero set: resolved, not taken
    do_branch(3'd1, 32'h0000_1000, 16'h0010, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle_cycle();

    // flag table
    for (int i = 0; i < 16; i++) begin
      do_branch(vecs[i].t, 32'h0001_0000 + 32'(i * 8), 16'h0020, vecs[i].z, vecs[i].lz, 0,
                vecs[i].exp_tk, vecs[i].exp_il);
      if (vecs[i].exp_tk) do_ack(1, model_target(32'h0001_0000 + 32'(i * 8), 16'h0020));
      else idle_cycle();
    end

    // BGTZ with operands late by three cycles
    do_branch(3'd3, 32'h0000_2000, 16'h0001, 1'b0, 1'b0, 3, 1'b1, 1'b0);
    do_ack(0, 32'h0000_2008);

    // target wrap cases
    do_branch(3'd4, 32'h0000_0000, 16'hFFFF, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    chk("wrap_back", redirect_pc, 32'h0000_0000);
    do_ack(0, 32'h0);
    do_branch(3'd4, 32'hFFFF_FFFC, 16'h0000, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    chk("wrap_top", redirect_pc, 32'h0000_0000);
    do_ack(0, 32'h0);

    // second branch waits behind an unacknowledged redirect
    do_branch(3'd0, 32'h0000_3000, 16'h0040, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    br_valid = 1'b1; br_type = 3'd4; pc_d = 32'h0000_3004; imm16 = 16'h0008;
    cmp_zero = 1'b0; cmp_lzero = 1'b0; opnd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_stall", stall_d, 1'b1);
      chk("hold_rv", redirect_valid, 1'b1);
      chk("hold_rpc", redirect_pc, 32'h0000_3104);
      @(posedge clk); #1;
      chk("hold_no_done", br_done, 1'b0);
    end
    fetch_ack = 1'b1;
    #1;
    chk("ack_cycle_stall", stall_d, 1'b1);
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    chk("ack_rv_drop", redirect_valid, 1'b0);
    chk("ack_no_eval", br_done, 1'b0);
    do_branch(3'd4, 32'h0000_3004, 16'h0008, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle_cycle();

    // flush while a redirect is pending
    do_branch(3'd0, 32'h0000_4000, 16'h0002, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_rv", redirect_valid, 1'b0);
    chk("flush_taken", taken_cnt, exp_taken_cnt);
    idle_cycle();

    // flush while waiting for operands drops the branch
    br_valid = 1'b1; br_type = 3'd0; pc_d = 32'h0000_5000; imm16 = 16'h0003;
    cmp_zero = 1'b1; cmp_lzero = 1'b0; opnd_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; opnd_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; br_valid = 1'b0; opnd_ready = 1'b0;
    chk("wflush_done", br_done, 1'b0);
    chk("wflush_rv", redirect_valid, 1'b0);
    chk("wflush_total", total_cnt, exp_total_cnt);
    chk("wflush_taken", taken_cnt, exp_taken_cnt);
    idle_cycle();

    // randomized branches from operand values
    for (int n = 0; n < 150; n++) begin
      t    = 3'($urandom_range(0, 7));
      d1   = int'($urandom_range(0, 6)) - 3;
      d2   = int'($urandom_range(0, 6)) - 3;
      diff = (t <= 3'd1) ? d1 - d2 : d1;
      case (t)
        3'd0:    tk = (d1 == d2);
        3'd1:    tk = (d1 != d2);
        3'd2:    tk = (d1 <= 0);
        3'd3:    tk = (d1 > 0);
        3'd4:    tk = (d1 < 0);
        3'd5:    tk = (d1 >= 0);
        default: tk = 1'b0;
      endcase
      pc   = $urandom & 32'hFFFF_FFFC;
      imm  = 16'($urandom_range(0, 65535));
      rdy  = int'($urandom_range(0, 3));
      do_branch(t, pc, imm, diff == 0, diff < 0, rdy, tk, t > 3'd5);
      if (tk) do_ack(int'($urandom_range(0, 3)), model_target(pc, imm));
      else idle_cycle();
    end

    // drive counters into saturation
    for (int n = 0; n < 260; n++) begin
      do_branch(3'd0, 32'h0000_6000, 16'h0001, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      do_ack(0, 32'h0000_6008);
    end
    chk("sat_taken", taken_cnt, CNT_MAX);
    chk("sat_total", total_cnt, CNT_MAX);

    // asynchronous reset while a redirect is pending
    do_branch(3'd0, 32'h0000_7000, 16'h0001, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rv", redirect_valid, 1'b0);
    chk("arst_rpc", redirect_pc, 32'h0);
    chk("arst_taken", taken_cnt, 0);
    chk("arst_total", total_cnt, 0);
    chk("arst_done", br_done, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    exp_taken_cnt = 0; exp_total_cnt = 0;
    @(posedge clk); #1;
    do_branch(3'd5, 32'h0000_8000, 16'h0002, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    do_ack(2, 32'h0000_800C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
